// File: rtl/zeroskip_stream_packer.sv
// Packs variable-length compacted activation groups into dense OUT_LANES-wide beats.
// Latency: a group accepted at edge N appears in out_data from cycle N+1.
// Backpressure: in_ready/out_valid decode from registered state only; a stalled beat holds stable.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input group handshake; in_data lanes packed from lane 0, in_cnt valid lanes
//   in_last             last group of a tile; flushes the partial beat
//   out_valid/out_ready output beat handshake; out_cnt valid lanes, out_last final beat of tile
//   err_cnt_ovf         sticky: an accepted group carried in_cnt > GROUP_NZ_MAX
module zeroskip_stream_packer #(
  parameter int GROUP_NZ_MAX = 16,
  parameter int OUT_LANES    = 16,
  parameter int DATA_W       = 8,
  localparam int BUF_LANES   = OUT_LANES + GROUP_NZ_MAX,
  localparam int CNT_W       = $clog2(GROUP_NZ_MAX + 1),
  localparam int FILL_W      = $clog2(BUF_LANES + 1),
  localparam int OCNT_W      = $clog2(OUT_LANES + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [GROUP_NZ_MAX-1:0][DATA_W-1:0]   in_data,
  input  logic [CNT_W-1:0]                      in_cnt,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [OUT_LANES-1:0][DATA_W-1:0]      out_data,
  output logic [OCNT_W-1:0]                     out_cnt,
  output logic                                  out_last,
  output logic                                  err_cnt_ovf
);

  typedef enum logic {S_FILL, S_FLUSH} state_t;

  localparam logic [FILL_W-1:0] L_OUT  = FILL_W'(OUT_LANES);
  localparam logic [CNT_W-1:0]  L_GMAX = CNT_W'(GROUP_NZ_MAX);

  logic [BUF_LANES-1:0][DATA_W-1:0] r_buf;
  logic [FILL_W-1:0]                r_fill;
  state_t                           r_state;
  logic                             r_err;

  logic [BUF_LANES-1:0][DATA_W-1:0] w_buf_nxt;
  logic [FILL_W-1:0]                w_base;
  logic [FILL_W-1:0]                w_fill_nxt;
  logic [CNT_W-1:0]                 w_eff;
  logic                             w_in_ready;
  logic                             w_out_valid;
  logic                             w_in_fire;
  logic                             w_out_fire;
  logic                             w_final_beat;

  // Accepting only while fill <= OUT_LANES bounds the buffer at BUF_LANES.
  assign w_in_ready   = !rst && (r_state == S_FILL) && (r_fill <= L_OUT);
  assign w_out_valid  = !rst && ((r_state == S_FLUSH) || (r_fill >= L_OUT));
  assign w_in_fire    = in_valid && w_in_ready;
  assign w_out_fire   = w_out_valid && out_ready;
  assign w_final_beat = (r_state == S_FLUSH) && (r_fill <= L_OUT);

  assign w_eff      = (in_cnt > L_GMAX) ? L_GMAX : in_cnt;
  // Write base accounts for a pop in the same cycle.
  assign w_base     = w_out_fire ? (r_fill - L_OUT) : r_fill;
  assign w_fill_nxt = w_base + (w_in_fire ? FILL_W'(w_eff) : '0);

  always_comb begin
    w_buf_nxt = r_buf;
    // Pop shifts the whole buffer down one beat; zeros enter from the top.
    if (w_out_fire) begin
      w_buf_nxt = r_buf >> (OUT_LANES * DATA_W);
    end
    if (w_in_fire) begin
      for (int j = 0; j < GROUP_NZ_MAX; j++) begin
        if ((j < int'(w_eff)) && ((int'(w_base) + j) < BUF_LANES)) begin
          w_buf_nxt[int'(w_base) + j] = in_data[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf   <= '0;
      r_fill  <= '0;
      r_state <= S_FILL;
      r_err   <= 1'b0;
    end else begin
      if (w_in_fire && (in_cnt > L_GMAX)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_FILL: begin
          r_buf  <= w_buf_nxt;
          r_fill <= w_fill_nxt;
          if (w_in_fire && in_last) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_out_fire) begin
            if (w_final_beat) begin
              r_buf   <= '0;
              r_fill  <= '0;
              r_state <= S_FILL;
            end else begin
              r_buf  <= w_buf_nxt;
              r_fill <= r_fill - L_OUT;
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign out_data    = r_buf[OUT_LANES-1:0];
  assign out_cnt     = (r_fill >= L_OUT) ? OCNT_W'(OUT_LANES) : OCNT_W'(r_fill);
  assign out_last    = w_final_beat;
  assign err_cnt_ovf = r_err;

endmodule

// File: tb/tb_zeroskip_stream_packer.sv
module tb_zeroskip_stream_packer;
  localparam int G = 16;
  localparam int O = 16;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [G-1:0][W-1:0] in_data = '0;
  logic [4:0]          in_cnt = '0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [O-1:0][W-1:0] out_data;
  logic [4:0]          out_cnt;
  logic                out_last;
  logic                err_cnt_ovf;

  zeroskip_stream_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_cnt(in_cnt), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cnt(out_cnt), .out_last(out_last), .err_cnt_ovf(err_cnt_ovf)
  );

  typedef struct {
    logic [O-1:0][W-1:0] data;
    int                  cnt;
    bit                  last;
  } beat_t;
  typedef logic [7:0] lanes_t [G];

  // Reference model: a flat queue of pending activations per tile.
  beat_t      exp_q[$];
  logic [7:0] pend[$];
  int         tile_cnt = 0;
  bit         exp_err = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int beats_seen = 0;
  bit rnd_done = 1'b0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic void emit(input int n, input bit last);
    beat_t b;
    b.data = '0;
    for (int i = 0; i < n; i++) b.data[i] = pend.pop_front();
    b.cnt  = n;
    b.last = last;
    exp_q.push_back(b);
  endfunction

  function automatic void model_push(input int cnt, input bit last, input lanes_t d);
    int eff;
    eff = (cnt > G) ? G : cnt;
    if (cnt > G) exp_err = 1'b1;
    for (int i = 0; i < eff; i++) pend.push_back(d[i]);
    tile_cnt += eff;
    if (!last) begin
      while (pend.size() >= O) emit(O, 1'b0);
    end else begin
      while (pend.size() > O) emit(O, 1'b0);
      emit(pend.size(), 1'b1);
      tile_cnt = 0;
    end
  endfunction

  function automatic lanes_t seq(input int start, input int n);
    lanes_t d;
    for (int i = 0; i < G; i++) d[i] = (i < n) ? 8'(start + i) : 8'($urandom);
    return d;
  endfunction

  // Inputs change at posedge+1; in_ready is already settled then.
  task automatic send(input int cnt, input bit last, input lanes_t d, output int waited);
    waited = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_cnt   = cnt[4:0];
    in_last  = last;
    for (int i = 0; i < G; i++) in_data[i] = d[i];
    while (in_ready !== 1'b1) begin
      if (waited >= 300) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        in_valid = 1'b0;
        return;
      end
      waited++;
      @(posedge clk); #1;
    end
    model_push(cnt, last, d);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); t++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted beat.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_beat got cnt=%0d last=%0d required=no beat", out_cnt, out_last);
        end else begin
          b = exp_q.pop_front();
          chk("beat_cnt", out_cnt, b.cnt);
          chk("beat_last", out_last, b.last);
          chk("beat_data", out_data, b.data);
        end
      end
    end
  end

  initial begin
    int w;
    int b0;
    int cnt;
    int eff;
    bit last;
    lanes_t d;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_out_cnt", out_cnt, 0);
    chk("post_rst_err", err_cnt_ovf, 0);

    // Two groups of 10 with a tile end
    @(posedge clk); #1 out_ready = 1'b1;
    send(10, 1'b0, seq(1, 10), w);
    send(10, 1'b1, seq(11, 10), w);
    idle();
    drain();

    // Full-width groups back to back
    b0 = beats_seen;
    for (int k = 0; k < 8; k++) begin
      send(16, 1'b0, seq(k * 16 + 1, 16), w);
      if (k > 0) begin
        chk("t2_no_stall", w, 0);
        chk("t2_out_valid", out_valid, 1);
      end
    end
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t2_beats", beats_seen - b0, 8);
    send(0, 1'b1, seq(0, 0), w);
    idle();
    drain();

    // Empty tile
    send(0, 1'b1, seq(0, 0), w);
    idle();
    drain();
    @(negedge clk);
    chk("t4_in_ready", in_ready, 1);
    chk("t4_out_valid", out_valid, 0);

    // Stall with 20 lanes buffered
    @(posedge clk); #1 out_ready = 1'b0;
    send(10, 1'b0, seq(1, 10), w);
    send(10, 1'b0, seq(11, 10), w);
    idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_in_ready", in_ready, 0);
      chk("t3_out_valid", out_valid, 1);
      chk("t3_out_data", out_data, (exp_q.size() > 0) ? exp_q[0].data : '0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("t3_in_ready_after", in_ready, 1);
    chk("t3_out_valid_after", out_valid, 0);
    send(0, 1'b1, seq(0, 0), w);
    idle();
    drain();

    // Oversized count
    chk("t5_err_before", err_cnt_ovf, 0);
    send(20, 1'b0, seq(1, 16), w);
    idle();
    @(negedge clk);
    chk("t5_err_set", err_cnt_ovf, 1);
    send(3, 1'b1, seq(17, 3), w);
    idle();
    drain();
    chk("t5_err_held", err_cnt_ovf, 1);

    // Reset while flushing 20 lanes
    @(posedge clk); #1 out_ready = 1'b0;
    send(10, 1'b0, seq(1, 10), w);
    send(10, 1'b1, seq(11, 10), w);
    idle();
    @(negedge clk);
    chk("t6_pre_out_valid", out_valid, 1);
    chk("t6_pre_out_last", out_last, 0);
    chk("t6_pre_in_ready", in_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    pend.delete();
    tile_cnt = 0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_out_cnt", out_cnt, 0);
    chk("t6_err_clr", err_cnt_ovf, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t6_no_stale", out_valid, 0);
    end

    // Randomized traffic with random backpressure
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int n = 0; n < 150; n++) begin
      cnt  = ($urandom_range(0, 19) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
      last = (n == 149) || ($urandom_range(0, 7) == 0);
      eff  = (cnt > G) ? G : cnt;
      // An empty closing group right behind an exact full beat leaves the last flag timing-dependent.
      if (last && eff == 0 && tile_cnt > 0 && (tile_cnt % O) == 0) cnt = 1;
      for (int i = 0; i < G; i++) d[i] = 8'($urandom);
      send(cnt, last, d, w);
    end
    idle();
    rnd_done = 1'b1;
    repeat (2) @(posedge clk);
    drain();
    chk("rnd_err", err_cnt_ovf, exp_err);
    @(negedge clk);
    chk("end_out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
